lsu_dmem: RTL and testbench

LSU_DMEM -- requirements
Module: lsu_dmem

---
 rtl/lsu_dmem.sv | 198 +++++++++++++++++++
 tb/tb_lsu_dmem.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem.sv
// rtl/lsu_dmem.sv - single-port data memory with load/store unit, fault capture and access counters
//
// Purpose:
//   Word-organised data memory for a load/store unit. Loads are combinational
//   (same-cycle ReadData), stores commit on the rising edge with byte enables.
//   Misaligned or illegal accesses raise Fault, are suppressed, and the first
//   one is captured in a sticky error register. Successful loads and stores
//   are counted in saturating 16-bit counters.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   Addr       in  32   byte address
//   WriteData  in  32   store data (low bits for byte/half stores)
//   MemWrite   in   1   store request
//   MemRead    in   1   load request
//   Funct3     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//   ErrClear   in   1   clears sticky error flag
//   ReadData   out 32   extended load result (combinational)
//   Fault      out  1   current access misaligned/illegal (combinational)
//   ErrValid   out  1   sticky fault-captured flag
//   ErrAddr    out 32   address of the captured fault
//   LoadCount  out 16   saturating count of successful loads
//   StoreCount out 16   saturating count of successful stores

module lsu_dmem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  Funct3,
  input  logic        ErrClear,
  output logic [31:0] ReadData,
  output logic        Fault,
  output logic        ErrValid,
  output logic [31:0] ErrAddr,
  output logic [15:0] LoadCount,
  output logic [15:0] StoreCount
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  // Memory array is intentionally not reset.
  logic [31:0] r_mem [DEPTH];

  logic          r_err_valid;
  logic [31:0]   r_err_addr;
  logic [15:0]   r_load_cnt;
  logic [15:0]   r_store_cnt;

  logic [AW-1:0] w_idx;
  logic          w_active;
  logic          w_illegal;
  logic          w_misalign;
  logic          w_fault;
  logic          w_store_ok;
  logic          w_load_ok;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_rdata;

  // Upper address bits are dropped, so the memory aliases every 4*DEPTH bytes.
  assign w_idx    = Addr[AW+1:2];
  assign w_active = MemRead | MemWrite;

  // Reserved encodings, plus unsigned variants which only make sense for loads.
  always_comb begin
    w_illegal = 1'b0;
    case (Funct3)
      F_B, F_H, F_W: w_illegal = 1'b0;
      F_BU, F_HU:    w_illegal = MemWrite;
      default:       w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_misalign = 1'b0;
    case (Funct3)
      F_H, F_HU: w_misalign = Addr[0];
      F_W:       w_misalign = (Addr[1:0] != 2'b00);
      default:   w_misalign = 1'b0;
    endcase
  end

  assign w_fault    = w_active & (w_illegal | w_misalign);
  // MemWrite wins when both requests are high, so that cycle is a store only.
  assign w_store_ok = MemWrite & ~w_fault;
  assign w_load_ok  = MemRead & ~MemWrite & ~w_fault;

  // Byte-lane enables and lane-replicated write data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    case (Funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << Addr[1:0];
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_be    = Addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteData;
      end
    endcase
  end

  // rst_n gates the write so a store sampled while reset is asserted is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && w_store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Combinational load path.
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_byte = w_word[7:0];
    case (Addr[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  assign w_half = Addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_rdata = 32'h0;
    case (Funct3)
      F_B:     w_rdata = {{24{w_byte[7]}}, w_byte};
      F_BU:    w_rdata = {24'h0, w_byte};
      F_H:     w_rdata = {{16{w_half[15]}}, w_half};
      F_HU:    w_rdata = {16'h0, w_half};
      F_W:     w_rdata = w_word;
      default: w_rdata = 32'h0;
    endcase
  end

  assign ReadData = w_load_ok ? w_rdata : 32'h0;
  assign Fault    = w_fault;

  // Sticky error capture. A fault is captured when nothing is held, or when
  // the held error is being cleared in the same cycle; the flag then stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= 32'h0;
    end else if (w_fault && (!r_err_valid || ErrClear)) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= Addr;
    end else if (ErrClear) begin
      r_err_valid <= 1'b0;
    end
  end

  // Saturating access counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt  <= 16'h0;
      r_store_cnt <= 16'h0;
    end else begin
      if (w_load_ok && (r_load_cnt != 16'hFFFF)) begin
        r_load_cnt <= r_load_cnt + 16'h1;
      end
      if (w_store_ok && (r_store_cnt != 16'hFFFF)) begin
        r_store_cnt <= r_store_cnt + 16'h1;
      end
    end
  end

  assign ErrValid   = r_err_valid;
  assign ErrAddr    = r_err_addr;
  assign LoadCount  = r_load_cnt;
  assign StoreCount = r_store_cnt;

endmodule

// File: tb/tb_lsu_dmem.sv
// tb/tb_lsu_dmem.sv - scoreboard testbench for lsu_dmem

module tb_lsu_dmem;

  localparam int K_RD = 0;
  localparam int K_FT = 1;
  localparam int K_EV = 2;
  localparam int K_EA = 3;
  localparam int K_LC = 4;
  localparam int K_SC = 5;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  Funct3;
  logic        ErrClear;
  logic [31:0] ReadData;
  logic        Fault;
  logic        ErrValid;
  logic [31:0] ErrAddr;
  logic [15:0] LoadCount;
  logic [15:0] StoreCount;

  exp_t exp_q[$];
  logic sample_req;
  int   n_checks;
  int   n_pass;

  lsu_dmem #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Funct3     (Funct3),
    .ErrClear   (ErrClear),
    .ReadData   (ReadData),
    .Fault      (Fault),
    .ErrValid   (ErrValid),
    .ErrAddr    (ErrAddr),
    .LoadCount  (LoadCount),
    .StoreCount (StoreCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: on the falling edge of every cycle the stimulus flags, pop and
  // compare all expectations queued for that cycle.
  always @(negedge clk) begin
    if (sample_req) begin
      while (exp_q.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = exp_q.pop_front();
        case (e.kind)
          K_RD:    act = ReadData;
          K_FT:    act = {31'h0, Fault};
          K_EV:    act = {31'h0, ErrValid};
          K_EA:    act = ErrAddr;
          K_LC:    act = {16'h0, LoadCount};
          default: act = {16'h0, StoreCount};
        endcase
        n_checks++;
        if (act === e.val) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got %08h expected %08h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic w, input logic r, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd, input logic clr);
    MemWrite  = w;
    MemRead   = r;
    Funct3    = f;
    Addr      = a;
    WriteData = wd;
    ErrClear  = clr;
  endtask

  // Run one cycle: the monitor samples at the falling edge, state updates at the rising edge.
  task automatic go();
    sample_req = 1'b1;
    @(posedge clk);
    #1;
    sample_req = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    sample_req = 1'b0;
    rst_n      = 1'b0;
    drive(0, 0, F_W, 32'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    expect_val(K_EV, 32'h0, "reset_errvalid");
    expect_val(K_EA, 32'h0, "reset_erraddr");
    expect_val(K_LC, 32'h0, "reset_loadcount");
    expect_val(K_SC, 32'h0, "reset_storecount");
    expect_val(K_FT, 32'h0, "reset_idle_fault");
    expect_val(K_RD, 32'h0, "reset_idle_rdata");
    go();
    rst_n = 1'b1;

    // Word round trip
    drive(1, 0, F_W, 32'h10, 32'hDEADBEEF, 0);
    expect_val(K_FT, 32'h0, "sw10_fault");
    expect_val(K_RD, 32'h0, "sw10_rdata_zero");
    go();
    drive(0, 1, F_W, 32'h10, 32'h0, 0);
    expect_val(K_RD, 32'hDEADBEEF, "lw10");
    expect_val(K_SC, 32'h1, "storecount_1");
    expect_val(K_LC, 32'h0, "loadcount_0");
    go();

    // Extension
    drive(0, 1, F_B, 32'h13, 32'h0, 0);
    expect_val(K_RD, 32'hFFFFFFDE, "lb13");
    expect_val(K_LC, 32'h1, "loadcount_1");
    go();
    drive(0, 1, F_BU, 32'h13, 32'h0, 0);
    expect_val(K_RD, 32'h000000DE, "lbu13");
    go();
    drive(0, 1, F_H, 32'h10, 32'h0, 0);
    expect_val(K_RD, 32'hFFFFBEEF, "lh10");
    go();
    drive(0, 1, F_HU, 32'h12, 32'h0, 0);
    expect_val(K_RD, 32'h0000DEAD, "lhu12");
    go();

    // Partial store
    drive(1, 0, F_B, 32'h11, 32'h000000AA, 0);
    expect_val(K_FT, 32'h0, "sb11_fault");
    go();
    drive(0, 1, F_W, 32'h10, 32'h0, 0);
    expect_val(K_RD, 32'hDEADAAEF, "lw10_after_sb");
    expect_val(K_SC, 32'h2, "storecount_2");
    expect_val(K_LC, 32'h5, "loadcount_5");
    go();
    drive(1, 0, F_W, 32'h20, 32'h11223344, 0);
    go();

    // Misaligned store
    drive(1, 0, F_W, 32'h22, 32'h12345678, 0);
    expect_val(K_FT, 32'h1, "sw22_fault");
    expect_val(K_EV, 32'h0, "sw22_errvalid_before");
    go();
    drive(0, 1, F_W, 32'h20, 32'h0, 0);
    expect_val(K_RD, 32'h11223344, "lw20_unchanged");
    expect_val(K_EV, 32'h1, "errvalid_after_sw22");
    expect_val(K_EA, 32'h22, "erraddr_22");
    expect_val(K_SC, 32'h3, "storecount_unchanged_3");
    go();
    drive(0, 1, F_H, 32'h31, 32'h0, 0);
    expect_val(K_FT, 32'h1, "lh31_fault");
    expect_val(K_RD, 32'h0, "lh31_rdata_zero");
    expect_val(K_LC, 32'h7, "loadcount_7");
    go();

    // Clear with no fault
    drive(0, 0, F_W, 32'h0, 32'h0, 1);
    expect_val(K_EA, 32'h22, "erraddr_kept_22");
    expect_val(K_EV, 32'h1, "errvalid_before_clear");
    expect_val(K_LC, 32'h7, "loadcount_no_inc_on_fault");
    go();
    drive(0, 1, F_W, 32'h33, 32'h0, 0);
    expect_val(K_EV, 32'h0, "errvalid_cleared");
    expect_val(K_EA, 32'h22, "erraddr_held_after_clear");
    expect_val(K_FT, 32'h1, "lw33_fault");
    go();

    // Clear with concurrent fault
    drive(0, 1, F_H, 32'h41, 32'h0, 1);
    expect_val(K_EV, 32'h1, "errvalid_33");
    expect_val(K_EA, 32'h33, "erraddr_33");
    go();
    drive(0, 1, 3'b011, 32'h10, 32'h0, 0);
    expect_val(K_EV, 32'h1, "errvalid_after_clear_fault");
    expect_val(K_EA, 32'h41, "erraddr_41");
    expect_val(K_FT, 32'h1, "funct3_011_fault");
    expect_val(K_RD, 32'h0, "funct3_011_rdata");
    go();
    drive(1, 0, F_BU, 32'h10, 32'hFFFFFFFF, 0);
    expect_val(K_FT, 32'h1, "store_bu_fault");
    go();
    drive(0, 1, F_W, 32'h10, 32'h0, 0);
    expect_val(K_RD, 32'hDEADAAEF, "lw10_after_bad_store");
    expect_val(K_SC, 32'h3, "storecount_3");
    expect_val(K_EA, 32'h41, "erraddr_41_held");
    go();

    // Both requests high resolves to store
    drive(1, 1, F_W, 32'h14, 32'hCAFEF00D, 0);
    expect_val(K_RD, 32'h0, "both_rdata_zero");
    expect_val(K_FT, 32'h0, "both_fault");
    expect_val(K_LC, 32'h8, "loadcount_8");
    go();
    drive(0, 1, F_W, 32'h14, 32'h0, 0);
    expect_val(K_RD, 32'hCAFEF00D, "lw14");
    expect_val(K_SC, 32'h4, "storecount_4");
    expect_val(K_LC, 32'h8, "loadcount_8_no_inc_both");
    go();

    // Aliasing at 4*DEPTH bytes
    drive(1, 0, F_W, 32'h400, 32'h0BADC0DE, 0);
    go();
    drive(0, 1, F_W, 32'h000, 32'h0, 0);
    expect_val(K_RD, 32'h0BADC0DE, "alias_lw0");
    go();

    // Mid-test reset, with a store held across the edge
    rst_n = 1'b0;
    drive(1, 0, F_W, 32'h10, 32'h55555555, 0);
    expect_val(K_LC, 32'h0, "midreset_loadcount");
    expect_val(K_SC, 32'h0, "midreset_storecount");
    expect_val(K_EV, 32'h0, "midreset_errvalid");
    expect_val(K_EA, 32'h0, "midreset_erraddr");
    go();
    rst_n = 1'b1;
    drive(0, 1, F_W, 32'h10, 32'h0, 0);
    expect_val(K_RD, 32'hDEADAAEF, "store_suppressed_in_reset");
    expect_val(K_SC, 32'h0, "storecount_0_after_reset");
    go();

    // Saturation: LoadCount is 1 here; 65534 more loads reach 0xFFFF
    for (int i = 0; i < 65534; i++) begin
      go();
    end
    expect_val(K_LC, 32'hFFFF, "loadcount_sat");
    go();
    expect_val(K_LC, 32'hFFFF, "loadcount_sat_hold");
    expect_val(K_RD, 32'hDEADAAEF, "lw10_final");
    go();

    drive(0, 0, F_W, 32'h0, 32'h0, 0);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
